// File: rtl/prio_rr_arbiter.sv
// Two-level arbiter: one high-priority requester (H) over N round-robin low-priority requesters (L).
// Latency: a grant pulse appears on the edge after a ready is sampled in IDLE. All outputs are registered.
// Backpressure: non-preemptive. A grant is held until the winner's go falls, or it is dropped after TIMEOUT cycles without go.
// Optional starvation guard: define ARB_STARVE_GUARD_EN. After three consecutive H grants made while L was waiting, the next selection goes to L.
module prio_rr_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bool_ready_H,
    input  logic         bool_go_H,
    input  logic [N-1:0] bool_ready_L,
    input  logic [N-1:0] bool_go_L,
    output logic         ena_n_H,
    output logic [N-1:0] ena_n_L,
    output logic [1:0]   active,
    output logic [3:0]   channel
);

    localparam logic [1:0] ACT_NONE = 2'b00;
    localparam logic [1:0] ACT_H    = 2'b01;
    localparam logic [1:0] ACT_L    = 2'b10;
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);
    localparam logic [4:0] N5       = 5'(N);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_WAIT_GO = 2'd2,
        S_BUSY    = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_ena_n_H;
    logic [N-1:0]   r_ena_n_L;
    logic [1:0]     r_active;
    logic [3:0]     r_channel;
    logic [3:0]     r_ptr;
    logic [7:0]     r_tmo_cnt;

    logic           w_ena_n_H_nxt;
    logic [N-1:0]   w_ena_n_L_nxt;
    logic [1:0]     w_active_nxt;
    logic [3:0]     w_channel_nxt;
    logic [3:0]     w_ptr_nxt;
    logic [7:0]     w_tmo_nxt;

    logic [15:0]    w_ready_l16;
    logic [15:0]    w_go_l16;
    logic [3:0]     w_cand;
    logic [3:0]     w_l_idx;
    logic           w_l_found;
    logic           w_force_l;
    logic           w_pick_h;
    logic           w_pick_l;
    logic           w_win_go;

    // Wrap (base + off) into 0..N-1. Because base < N and off <= N, one subtraction is always enough.
    function automatic logic [3:0] wrap_idx(input logic [3:0] base, input logic [4:0] off);
        logic [4:0] s;
        s = {1'b0, base} + off;
        if (s >= N5) begin
            s = s - N5;
        end
        return s[3:0];
    endfunction

    // Zero-extend the L vectors to 16 bits so that a 4-bit index always addresses them exactly.
    assign w_ready_l16 = 16'(bool_ready_L);
    assign w_go_l16    = 16'(bool_go_L);

    // Round-robin search: the first ready L, scanning upward from ptr+1 and wrapping at N.
    always_comb begin
        w_l_found = 1'b0;
        w_l_idx   = 4'd0;
        w_cand    = 4'd0;
        for (int i = 1; i <= N; i++) begin
            w_cand = wrap_idx(r_ptr, 5'(i));
            if (!w_l_found && w_ready_l16[w_cand]) begin
                w_l_found = 1'b1;
                w_l_idx   = w_cand;
            end
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [1:0] r_starve_cnt;
    logic [1:0] w_starve_nxt;

    // Once three H grants have gone by while L was waiting, the next selection is forced to L.
    assign w_force_l = (r_starve_cnt == 2'd3) && w_l_found;

    // Count H grants that bypassed a waiting L. Any L grant resets the count.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (r_state == S_IDLE) begin
            if (w_pick_l) begin
                w_starve_nxt = 2'd0;
            end else if (w_pick_h && w_l_found && (r_starve_cnt != 2'd3)) begin
                w_starve_nxt = r_starve_cnt + 2'd1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 2'd0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end
`else
    assign w_force_l = 1'b0;
`endif

    assign w_pick_h = bool_ready_H && !w_force_l;
    assign w_pick_l = !w_pick_h && w_l_found;

    // Only the current winner's go counts. Go from any other requester is ignored.
    assign w_win_go = (r_active == ACT_H) ? bool_go_H :
                      (r_active == ACT_L) ? w_go_l16[r_channel] : 1'b0;

    // Next state and next register values. The ena_n outputs default to inactive, so a grant pulse lasts exactly one cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_ena_n_H_nxt = 1'b1;
        w_ena_n_L_nxt = '1;
        w_active_nxt  = r_active;
        w_channel_nxt = r_channel;
        w_ptr_nxt     = r_ptr;
        w_tmo_nxt     = r_tmo_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_h) begin
                    w_state_nxt   = S_GRANT;
                    w_ena_n_H_nxt = 1'b0;
                    w_active_nxt  = ACT_H;
                    w_channel_nxt = 4'd0;
                    w_tmo_nxt     = TMO_LOAD;
                end else if (w_pick_l) begin
                    w_state_nxt   = S_GRANT;
                    w_ena_n_L_nxt = ~(N'(1) << w_l_idx);
                    w_active_nxt  = ACT_L;
                    w_channel_nxt = w_l_idx;
                    w_ptr_nxt     = w_l_idx;
                    w_tmo_nxt     = TMO_LOAD;
                end
            end
            S_GRANT: begin
                w_state_nxt = S_WAIT_GO;
            end
            S_WAIT_GO: begin
                if (r_tmo_cnt != 8'd0) begin
                    w_tmo_nxt = r_tmo_cnt - 8'd1;
                end
                if (w_win_go) begin
                    w_state_nxt = S_BUSY;
                end else if (r_tmo_cnt <= 8'd1) begin
                    // The counter reaches 0 on this edge, so the grant is abandoned.
                    w_state_nxt   = S_IDLE;
                    w_active_nxt  = ACT_NONE;
                    w_channel_nxt = 4'd0;
                end
            end
            S_BUSY: begin
                if (!w_win_go) begin
                    w_state_nxt   = S_IDLE;
                    w_active_nxt  = ACT_NONE;
                    w_channel_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_active_nxt  = ACT_NONE;
                w_channel_nxt = 4'd0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output, pointer and timeout registers. After reset, ptr = N-1 so the first L search starts at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ena_n_H <= 1'b1;
            r_ena_n_L <= '1;
            r_active  <= ACT_NONE;
            r_channel <= 4'd0;
            r_ptr     <= 4'(N - 1);
            r_tmo_cnt <= 8'd0;
        end else begin
            r_ena_n_H <= w_ena_n_H_nxt;
            r_ena_n_L <= w_ena_n_L_nxt;
            r_active  <= w_active_nxt;
            r_channel <= w_channel_nxt;
            r_ptr     <= w_ptr_nxt;
            r_tmo_cnt <= w_tmo_nxt;
        end
    end

    assign ena_n_H = r_ena_n_H;
    assign ena_n_L = r_ena_n_L;
    assign active  = r_active;
    assign channel = r_channel;

endmodule

// File: doc/prio_rr_arbiter.md
PRIO_RR_ARBITER -- requirements
Module: prio_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 2: number of low-priority (L) requesters, 1..16.
REQ-002 SHALL have parameter TIMEOUT, default 8: cycles to wait for go after a grant, 1..255.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port bool_ready_H, input, 1: high-priority requester ready.
REQ-006 SHALL have port bool_go_H, input, 1: high-priority requester busy.
REQ-007 SHALL have port bool_ready_L, input, N: low-priority requesters ready.
REQ-008 SHALL have port bool_go_L, input, N: low-priority requesters busy.
REQ-009 SHALL have port ena_n_H, output, 1: active-low grant to H.
REQ-010 SHALL have port ena_n_L, output, N: active-low grants to L.
REQ-011 SHALL have port active, output, 2: 00 none, 01 H, 10 L; 11 never driven.
REQ-012 SHALL have port channel, output, 4: index of the granted L requester; 0 when active is 00 or 01.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have four states: IDLE, GRANT, WAIT_GO and BUSY.
REQ-015 In IDLE, when any ready is sampled high, the FSM SHALL select a winner and enter GRANT on the next edge.
REQ-016 The winner SHALL be H whenever bool_ready_H is high; otherwise it SHALL be the first ready L index searched upward from ptr+1, modulo N.
REQ-017 In GRANT, exactly one ena_n bit (the winner's) SHALL be low for exactly one clock, and the FSM SHALL then enter WAIT_GO.
REQ-018 In WAIT_GO, a high go from the winner SHALL move the FSM to BUSY.
REQ-019 In WAIT_GO, after TIMEOUT cycles with no go from the winner, the FSM SHALL abandon the grant and return to IDLE.
REQ-020 In BUSY, the FSM SHALL hold until the winner's go is sampled low, then return to IDLE.
REQ-021 Arbitration SHALL be non-preemptive: H becoming ready during GRANT, WAIT_GO or BUSY SHALL NOT disturb the current grant.
REQ-022 A winner's ready falling during WAIT_GO or BUSY SHALL be ignored; only go and the timeout end a grant.
REQ-023 ptr SHALL update to the winning L index on entry to GRANT; H grants SHALL NOT change ptr.
REQ-024 A timed-out L grant SHALL still advance ptr, so the failing requester moves to the lowest priority.
REQ-025 active and channel SHALL be set on entry to GRANT, held through BUSY, and cleared to 00/0 on the edge that returns to IDLE.
REQ-026 go from any non-winner SHALL be ignored.
REQ-027 IDLE SHALL last at least one cycle between grants.
REQ-028 The timeout counter SHALL be 8 bits wide, SHALL load TIMEOUT on GRANT, SHALL decrement in WAIT_GO, and SHALL fire at 0.

Reset
REQ-029 With rst high at a rising edge, the FSM SHALL be IDLE, ena_n_H=1, ena_n_L all 1, active=00, channel=0, ptr=N-1 (first L search starts at index 0), timeout counter=0 and starve counter=0.
REQ-030 Reset asserted mid-grant, in any state, SHALL abort the grant on that edge, with no further ena_n low pulse.

Configuration
REQ-031 Macro ARB_STARVE_GUARD_EN SHALL compile the starvation guard in or out.
REQ-032 With ARB_STARVE_GUARD_EN defined, a 2-bit counter SHALL count consecutive H grants made while any bool_ready_L is high.
REQ-033 With ARB_STARVE_GUARD_EN defined, at a count of 3, the next selection SHALL go to L even if H is ready, and the counter SHALL then clear.
REQ-034 With ARB_STARVE_GUARD_EN defined, any L grant SHALL clear the counter.
REQ-035 Without ARB_STARVE_GUARD_EN, H SHALL always win when ready, and no counter logic SHALL exist.

Verification
REQ-036 Scenario, N=2: bool_ready_H rises, go goes high 1 cycle after the ena_n_H pulse and lasts 16 cycles -> ena_n_H low for 1 cycle, active=01 until go falls, ptr unchanged.
REQ-037 Scenario: bool_ready_L=11 held, each go lasts 12 cycles -> grants alternate L0, L1, L0, with channel 0, 1, 0.
REQ-038 Scenario: L0 is granted and never raises go, TIMEOUT=8 -> return to IDLE 8 cycles after WAIT_GO entry, next grant to L1.
REQ-039 Scenario: H ready during an L1 BUSY period -> L1 keeps the grant until its go falls, then H is granted next.
REQ-040 Scenario: rst pulsed for 1 cycle in BUSY -> all ena_n=1, active=00 on that edge, and the next grant goes to L0.
REQ-041 Scenario: with ARB_STARVE_GUARD_EN, H and L0 continuously ready -> grant order H, H, H, L0, H...; without the macro, H only.
